// File: rtl/dac_tdm_ser.sv
`default_nettype none
// ============================================================================
// Module   : dac_tdm_ser
// Brief    : Multi-channel TDM serial DAC driver with a one-deep shadow word,
//            frame repeat and channel-select / frame-sync word clock.
// Revision : 1.0 - initial release
// ============================================================================
module dac_tdm_ser #(
    parameter int WIDTH   = 16,
    parameter int NCH     = 2,
    parameter int REPEAT  = 1,
    parameter int WS_MODE = 0
) (
    input  logic                 bitclk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] din,
    input  logic                 nw,
    output logic                 accept,
    output logic                 busy,
    output logic                 wout,
    output logic                 bout,
    output logic                 dout
);

    localparam int   c_F       = NCH * WIDTH;
    localparam int   c_BW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int   c_CW      = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic c_WS_IDLE = (WS_MODE == 0) ? 1'b1 : 1'b0;

    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_SHIFT = 1'b1;

    logic [0:0]       r_state, w_state_nxt;
    logic             r_phase, w_phase_nxt;
    logic [c_BW-1:0]  r_bit, w_bit_nxt;
    logic [c_CW-1:0]  r_ch, w_ch_nxt;
    logic [3:0]       r_rep, w_rep_nxt;
    logic [c_F-1:0]   r_active, w_active_nxt;
    logic [c_F-1:0]   r_shadow, w_shadow_nxt;
    logic             r_shadow_valid, w_shadow_valid_nxt;
    logic             r_accept, w_accept_nxt;
    logic             r_bout, w_bout_nxt;
    logic             r_dout, w_dout_nxt;
    logic             r_wout, w_wout_nxt;
    logic             w_drive;
    logic             w_last;
    logic             w_nw_ok;
    logic [WIDTH-1:0] w_word;

    // r_bit counts down from the MSB; last bit of a frame is bit 0 of the top channel
    assign w_last  = (r_ch == c_CW'(NCH - 1)) && (r_bit == '0);
    // a request directly after an accept is the same nw level and is not taken again
    assign w_nw_ok = nw && !r_accept;

    always_ff @(posedge bitclk) begin
        if (rst) begin
            r_state        <= c_S_IDLE;
            r_phase        <= 1'b0;
            r_bit          <= '0;
            r_ch           <= '0;
            r_rep          <= '0;
            r_active       <= '0;
            r_shadow       <= '0;
            r_shadow_valid <= 1'b0;
            r_accept       <= 1'b0;
            r_bout         <= 1'b0;
            r_dout         <= 1'b0;
            r_wout         <= c_WS_IDLE;
        end else begin
            r_state        <= w_state_nxt;
            r_phase        <= w_phase_nxt;
            r_bit          <= w_bit_nxt;
            r_ch           <= w_ch_nxt;
            r_rep          <= w_rep_nxt;
            r_active       <= w_active_nxt;
            r_shadow       <= w_shadow_nxt;
            r_shadow_valid <= w_shadow_valid_nxt;
            r_accept       <= w_accept_nxt;
            r_bout         <= w_bout_nxt;
            r_dout         <= w_dout_nxt;
            r_wout         <= w_wout_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_phase_nxt        = r_phase;
        w_bit_nxt          = r_bit;
        w_ch_nxt           = r_ch;
        w_rep_nxt          = r_rep;
        w_active_nxt       = r_active;
        w_shadow_nxt       = r_shadow;
        w_shadow_valid_nxt = r_shadow_valid;
        w_accept_nxt       = 1'b0;
        w_drive            = 1'b0;

        case (r_state)
            c_S_IDLE: begin
                if (nw) begin
                    w_state_nxt  = c_S_SHIFT;
                    w_active_nxt = din;
                    w_accept_nxt = 1'b1;
                    w_rep_nxt    = 4'(REPEAT);
                    w_drive      = 1'b1;
                end
            end
            default: begin
                if (!r_phase || !w_last) begin
                    w_phase_nxt = 1'b1;
                    w_drive     = r_phase;
                    if (w_nw_ok && !r_shadow_valid) begin
                        w_shadow_nxt       = din;
                        w_shadow_valid_nxt = 1'b1;
                        w_accept_nxt       = 1'b1;
                    end
                end else if (r_shadow_valid) begin
                    // gapless hand-over; the freed shadow may refill on the same edge
                    w_active_nxt       = r_shadow;
                    w_shadow_valid_nxt = 1'b0;
                    w_rep_nxt          = 4'(REPEAT);
                    w_drive            = 1'b1;
                    if (w_nw_ok) begin
                        w_shadow_nxt       = din;
                        w_shadow_valid_nxt = 1'b1;
                        w_accept_nxt       = 1'b1;
                    end
                end else if (nw) begin
                    w_active_nxt = din;
                    w_accept_nxt = 1'b1;
                    w_rep_nxt    = 4'(REPEAT);
                    w_drive      = 1'b1;
                end else if (r_rep != 4'd0) begin
                    w_rep_nxt = r_rep - 4'd1;
                    w_drive   = 1'b1;
                end else begin
                    w_state_nxt = c_S_IDLE;
                end
            end
        endcase

        if (w_drive) begin
            w_phase_nxt = 1'b0;
            if (r_state == c_S_IDLE || w_last) begin
                w_bit_nxt = c_BW'(WIDTH - 1);
                w_ch_nxt  = '0;
            end else if (r_bit == '0) begin
                w_bit_nxt = c_BW'(WIDTH - 1);
                w_ch_nxt  = r_ch + c_CW'(1);
            end else begin
                w_bit_nxt = r_bit - c_BW'(1);
            end
        end
    end

    always_comb begin
        w_bout_nxt = r_bout;
        w_dout_nxt = r_dout;
        w_wout_nxt = r_wout;
        w_word     = w_active_nxt[WIDTH-1:0];
        for (int c = 0; c < NCH; c++) begin
            if (w_ch_nxt == c_CW'(c)) begin
                w_word = w_active_nxt[c*WIDTH +: WIDTH];
            end
        end

        if (w_state_nxt == c_S_IDLE) begin
            w_bout_nxt = 1'b0;
            w_dout_nxt = 1'b0;
            w_wout_nxt = c_WS_IDLE;
        end else if (w_drive) begin
            w_bout_nxt = 1'b0;
            w_dout_nxt = w_word[w_bit_nxt];
            if (WS_MODE == 0) begin
                w_wout_nxt = w_ch_nxt[0];
            end else begin
                w_wout_nxt = (w_ch_nxt == '0) && (w_bit_nxt == c_BW'(WIDTH - 1));
            end
        end else if (!r_phase) begin
            w_bout_nxt = 1'b1;
        end
    end

    assign accept = r_accept;
    assign busy   = (r_state == c_S_SHIFT);
    assign wout   = r_wout;
    assign bout   = r_bout;
    assign dout   = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_dac_tdm_ser.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_tdm_ser
// Brief    : Self-checking bench: two DAC serializers (channel-select 16x2 and
//            frame-sync 8x4) against a frame-timeline reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_tdm_ser;

    logic        bitclk;
    logic        rst;
    logic [31:0] din;
    logic        nw0, nw1;
    logic        accept0, busy0, wout0, bout0, dout0;
    logic        accept1, busy1, wout1, bout1, dout1;

    int n_checks = 0;
    int n_pass   = 0;

    dac_tdm_ser #(.WIDTH(16), .NCH(2), .REPEAT(1), .WS_MODE(0)) u_dut0 (
        .bitclk(bitclk), .rst(rst), .din(din), .nw(nw0),
        .accept(accept0), .busy(busy0), .wout(wout0), .bout(bout0), .dout(dout0)
    );

    dac_tdm_ser #(.WIDTH(8), .NCH(4), .REPEAT(0), .WS_MODE(1)) u_dut1 (
        .bitclk(bitclk), .rst(rst), .din(din), .nw(nw1),
        .accept(accept1), .busy(busy1), .wout(wout1), .bout(bout1), .dout(dout1)
    );

    initial bitclk = 1'b0;
    always #5 bitclk = ~bitclk;

    // Reference model: each instance tracks the edge offset t since its frame
    // started; outputs follow from t alone (bit = t/2, bout = t odd).
    logic [31:0] m_data [2];
    logic [31:0] m_shd  [2];
    int          m_t    [2];
    int          m_rep  [2];
    bit          m_busy [2];
    bit          m_shv  [2];
    bit          m_acc  [2];
    logic [4:0]  e_out  [2];   // {accept, busy, wout, bout, dout}

    logic [9:0] obs, expv;
    assign obs  = {accept0, busy0, wout0, bout0, dout0, accept1, busy1, wout1, bout1, dout1};
    assign expv = {e_out[0], e_out[1]};

    task automatic model_step();
        int w, rp, b, ch;
        bit n, a, wv;
        for (int m = 0; m < 2; m++) begin
            w  = (m == 0) ? 16 : 8;
            rp = (m == 0) ? 1 : 0;
            n  = (m == 0) ? nw0 : nw1;
            a  = 1'b0;
            if (rst) begin
                m_busy[m] = 0; m_shv[m] = 0; m_rep[m] = 0; m_acc[m] = 0;
            end else if (!m_busy[m]) begin
                m_acc[m] = n;
                if (n) begin
                    m_busy[m] = 1; m_t[m] = 0; m_data[m] = din; m_rep[m] = rp;
                end
            end else begin
                m_t[m] = m_t[m] + 1;
                if (m_t[m] == 64) begin
                    if (m_shv[m]) begin
                        m_data[m] = m_shd[m]; m_shv[m] = 0; m_rep[m] = rp; m_t[m] = 0;
                        if (n && !m_acc[m]) begin m_shd[m] = din; m_shv[m] = 1; a = 1; end
                    end else if (n) begin
                        m_data[m] = din; m_rep[m] = rp; m_t[m] = 0; a = 1;
                    end else if (m_rep[m] > 0) begin
                        m_rep[m] = m_rep[m] - 1; m_t[m] = 0;
                    end else begin
                        m_busy[m] = 0;
                    end
                end else if (n && !m_shv[m] && !m_acc[m]) begin
                    m_shd[m] = din; m_shv[m] = 1; a = 1;
                end
                m_acc[m] = a;
            end
            if (m_busy[m]) begin
                b  = m_t[m] / 2;
                ch = b / w;
                wv = (m == 0) ? ((ch % 2) == 1) : (b == 0);
                e_out[m] = {m_acc[m], 1'b1, wv, (m_t[m] % 2) == 1, m_data[m][ch*w + w - 1 - (b % w)]};
            end else begin
                e_out[m] = {m_acc[m], 1'b0, (m == 0), 1'b0, 1'b0};
            end
        end
    endtask

    initial forever begin
        @(posedge bitclk);
        model_step();
    end

    task automatic test_reset();
        rst = 1'b1; nw0 = 1'b1; nw1 = 1'b1; din = $urandom;
        for (int i = 0; i < 4; i++) begin
            @(negedge bitclk);
            if (i == 2) begin rst = 1'b0; nw0 = 1'b0; nw1 = 1'b0; end
            n_checks++;
            if (obs !== 10'b00100_00000) $display("FAIL reset_idle cyc %0d: got %b want 0010000000", i, obs);
            else n_pass++;
        end
    endtask

    task automatic test_single_word();
        logic [31:0] col = '0;
        din = 32'hBEEF_A5C3; nw0 = 1'b1;
        for (int i = 0; i < 132; i++) begin
            @(negedge bitclk);
            nw0 = 1'b0;
            n_checks++;
            if (obs !== expv) $display("FAIL single_model cyc %0d: dut=%b model=%b", i, obs, expv);
            else n_pass++;
            if (i < 64 && (i % 2) == 1) col = {col[30:0], dout0};
            if (i == 0) begin
                n_checks++;
                if (accept0 !== 1'b1) $display("FAIL single_accept: got %b want 1", accept0); else n_pass++;
            end
            if (i == 31 || i == 32) begin
                n_checks++;
                if (wout0 !== (i == 32)) $display("FAIL single_wout cyc %0d: got %b want %b", i, wout0, i == 32);
                else n_pass++;
            end
            if (i == 127 || i == 128) begin
                n_checks++;
                if (busy0 !== (i == 127)) $display("FAIL single_busy cyc %0d: got %b want %b", i, busy0, i == 127);
                else n_pass++;
            end
        end
        n_checks++;
        if (col !== 32'hA5C3_BEEF) $display("FAIL single_bits: got %h want a5c3beef", col);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] col = '0;
        bit gap = 1'b0;
        din = 32'hBEEF_A5C3; nw0 = 1'b1;
        for (int i = 0; i < 196; i++) begin
            @(negedge bitclk);
            nw0 = (i + 1 == 10);
            if (i + 1 == 10) din = 32'h0001_8000;
            n_checks++;
            if (obs !== expv) $display("FAIL b2b_model cyc %0d: dut=%b model=%b", i, obs, expv);
            else n_pass++;
            if (i < 192 && busy0 !== 1'b1) gap = 1'b1;
            if (i >= 64 && i < 128 && ((i - 64) % 2) == 1) col = {col[30:0], dout0};
            if (i == 10) begin
                n_checks++;
                if (accept0 !== 1'b1) $display("FAIL b2b_accept: got %b want 1", accept0); else n_pass++;
            end
            if (i == 64) begin
                n_checks++;
                if (bout0 !== 1'b0) $display("FAIL b2b_bout_edge: got %b want 0", bout0); else n_pass++;
            end
            if (i == 192) begin
                n_checks++;
                if (busy0 !== 1'b0) $display("FAIL b2b_end_busy: got %b want 0", busy0); else n_pass++;
            end
        end
        n_checks++;
        if (gap) $display("FAIL b2b_gap: got busy gap want none"); else n_pass++;
        n_checks++;
        if (col !== 32'h8000_0001) $display("FAIL b2b_frame2: got %h want 80000001", col); else n_pass++;
    endtask

    task automatic test_shadow_full();
        logic [31:0] a, b2;
        logic [31:0] col = '0;
        a = $urandom; b2 = $urandom;
        if (b2 == a) b2 = ~a;
        din = $urandom; nw0 = 1'b1;
        for (int i = 0; i < 196; i++) begin
            @(negedge bitclk);
            nw0 = (i + 1 == 10) || (i + 1 == 20);
            if (i + 1 == 10) din = a;
            if (i + 1 == 20) din = b2;
            n_checks++;
            if (obs !== expv) $display("FAIL shfull_model cyc %0d: dut=%b model=%b", i, obs, expv);
            else n_pass++;
            if (i >= 64 && i < 128 && ((i - 64) % 2) == 1) col = {col[30:0], dout0};
            if (i == 10 || i == 20) begin
                n_checks++;
                if (accept0 !== (i == 10)) $display("FAIL shfull_accept cyc %0d: got %b want %b", i, accept0, i == 10);
                else n_pass++;
            end
        end
        n_checks++;
        if (col !== {a[15:0], a[31:16]}) $display("FAIL shfull_frame2: got %h want %h", col, {a[15:0], a[31:16]});
        else n_pass++;
    endtask

    task automatic test_boundary_load();
        logic [31:0] c;
        logic [31:0] col = '0;
        c = $urandom;
        din = $urandom; nw0 = 1'b1;
        for (int i = 0; i < 196; i++) begin
            @(negedge bitclk);
            nw0 = (i + 1 == 64);
            if (i + 1 == 64) din = c;
            n_checks++;
            if (obs !== expv) $display("FAIL bload_model cyc %0d: dut=%b model=%b", i, obs, expv);
            else n_pass++;
            if (i >= 64 && i < 128 && ((i - 64) % 2) == 1) col = {col[30:0], dout0};
            if (i == 64) begin
                n_checks++;
                if (accept0 !== 1'b1) $display("FAIL bload_accept: got %b want 1", accept0); else n_pass++;
            end
            if (i == 191 || i == 192) begin
                n_checks++;
                if (busy0 !== (i == 191)) $display("FAIL bload_busy cyc %0d: got %b want %b", i, busy0, i == 191);
                else n_pass++;
            end
        end
        n_checks++;
        if (col !== {c[15:0], c[31:16]}) $display("FAIL bload_frame: got %h want %h", col, {c[15:0], c[31:16]});
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] f;
        logic [31:0] col = '0;
        f = $urandom;
        din = $urandom; nw0 = 1'b1;
        for (int i = 0; i < 172; i++) begin
            @(negedge bitclk);
            nw0 = (i + 1 == 40);
            rst = (i + 1 == 37);
            if (i + 1 == 40) din = f;
            n_checks++;
            if (obs !== expv) $display("FAIL rstmid_model cyc %0d: dut=%b model=%b", i, obs, expv);
            else n_pass++;
            if (i >= 40 && i < 104 && ((i - 40) % 2) == 1) col = {col[30:0], dout0};
            if (i == 37) begin
                n_checks++;
                if ({bout0, dout0, wout0, busy0} !== 4'b0010)
                    $display("FAIL rstmid_idle: got bout/dout/wout/busy=%b want 0010", {bout0, dout0, wout0, busy0});
                else n_pass++;
            end
        end
        n_checks++;
        if (col !== {f[15:0], f[31:16]}) $display("FAIL rstmid_frame: got %h want %h", col, {f[15:0], f[31:16]});
        else n_pass++;
    endtask

    task automatic test_frame_sync();
        logic [7:0] col = '0;
        bit wbad = 1'b0;
        din = 32'h1122_3344; nw1 = 1'b1;
        for (int i = 0; i < 68; i++) begin
            @(negedge bitclk);
            nw1 = 1'b0;
            n_checks++;
            if (obs !== expv) $display("FAIL fsync_model cyc %0d: dut=%b model=%b", i, obs, expv);
            else n_pass++;
            if (i < 64 && wout1 !== (i < 2)) wbad = 1'b1;
            if (i < 16 && (i % 2) == 1) col = {col[6:0], dout1};
            if (i == 63 || i == 64) begin
                n_checks++;
                if (busy1 !== (i == 63)) $display("FAIL fsync_busy cyc %0d: got %b want %b", i, busy1, i == 63);
                else n_pass++;
            end
        end
        n_checks++;
        if (wbad) $display("FAIL fsync_wout: got wout outside edges N,N+1 want pulse only there"); else n_pass++;
        n_checks++;
        if (col !== 8'h44) $display("FAIL fsync_byte0: got %h want 44", col); else n_pass++;
    endtask

    task automatic test_nw_held();
        bit prev = 1'b0;
        bit dbl  = 1'b0;
        din = $urandom; nw0 = 1'b1;
        for (int i = 0; i < 450; i++) begin
            @(negedge bitclk);
            nw0 = (i < 150);
            din = $urandom;
            n_checks++;
            if (obs !== expv) $display("FAIL held_model cyc %0d: dut=%b model=%b", i, obs, expv);
            else n_pass++;
            if (prev && accept0) dbl = 1'b1;
            prev = accept0;
        end
        n_checks++;
        if (dbl) $display("FAIL held_accept: got accept on consecutive edges want none"); else n_pass++;
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 800; i++) begin
                @(negedge bitclk);
                nw0 = (i < 500) && ($urandom_range(0, 15) == 0);
                nw1 = (i < 500) && ($urandom_range(0, 11) == 0);
                rst = (i < 500) && ($urandom_range(0, 399) == 0);
                din = $urandom;
                n_checks++;
                if (obs !== expv) $display("FAIL random_model rnd %0d cyc %0d: dut=%b model=%b", r, i, obs, expv);
                else n_pass++;
            end
            n_checks++;
            if ({busy0, busy1} !== 2'b00) $display("FAIL random_drain rnd %0d: got busy=%b want 00", r, {busy0, busy1});
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1; nw0 = 1'b0; nw1 = 1'b0; din = '0;
        @(negedge bitclk);
        test_reset();
        test_single_word();
        test_back_to_back();
        test_shadow_full();
        test_boundary_load();
        test_reset_mid_frame();
        test_frame_sync();
        test_nw_held();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
